// File: rtl/timebase_counter.sv
// Cascaded time-base counter: prescaled ticks ripple a carry through
// NUM_STAGES digit stages, with load/clear, overflow handling and an alarm.
module timebase_counter #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_W    = 10,
    parameter int STAGE_MAX  = 999,
    parameter int TICK_DIV   = 1,
    parameter bit SAT_TOP    = 1'b0
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          load,
    input  logic [NUM_STAGES*STAGE_W-1:0] load_val,
    input  logic                          alarm_arm,
    input  logic                          alarm_cancel,
    input  logic [NUM_STAGES*STAGE_W-1:0] alarm_val,
    input  logic                          alarm_periodic,
    output logic [NUM_STAGES*STAGE_W-1:0] count,
    output logic                          tick,
    output logic [NUM_STAGES-1:0]         stage_wrap,
    output logic                          overflow,
    output logic                          alarm_armed,
    output logic                          alarm_hit
);

    localparam int CW = NUM_STAGES * STAGE_W;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [STAGE_W-1:0] SMAX = STAGE_W'(STAGE_MAX);
    localparam logic [PW-1:0]      PTOP = PW'(TICK_DIV - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic                  tick_q, tick_d;
    logic [NUM_STAGES-1:0] wrap_q, wrap_d;
    logic                  ovf_q, ovf_d;
    logic                  armed_q, armed_d;
    logic                  hit_q, hit_d;
    logic [CW-1:0]         tgt_q, tgt_d;
    logic                  per_q, per_d;
    logic                  rst_pend_q, rst_pend_d;

    logic [CW-1:0]         inc_cnt;
    logic [NUM_STAGES-1:0] inc_wrap;
    logic                  carry;
    logic [CW-1:0]         ld_cnt;

    always_comb begin
        inc_cnt  = cnt_q;
        inc_wrap = '0;
        carry    = 1'b1;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (carry) begin
                if (cnt_q[i*STAGE_W +: STAGE_W] == SMAX) begin
                    inc_cnt[i*STAGE_W +: STAGE_W] = '0;
                    inc_wrap[i] = 1'b1;
                end else begin
                    inc_cnt[i*STAGE_W +: STAGE_W] =
                        cnt_q[i*STAGE_W +: STAGE_W] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        // Saturating top: a full-scale count simply holds
        if (carry && SAT_TOP) begin
            inc_cnt  = cnt_q;
            inc_wrap = '0;
        end
    end

    always_comb begin
        ld_cnt = load_val;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (load_val[i*STAGE_W +: STAGE_W] > SMAX) begin
                ld_cnt[i*STAGE_W +: STAGE_W] = SMAX;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        tick_d     = 1'b0;
        wrap_d     = '0;
        ovf_d      = ovf_q;
        armed_d    = armed_q;
        hit_d      = 1'b0;
        tgt_d      = tgt_q;
        per_d      = per_q;
        rst_pend_d = rst_pend_q;

        if (clr) begin
            cnt_d      = '0;
            pre_d      = '0;
            ovf_d      = 1'b0;
            rst_pend_d = 1'b0;
        end else if (load) begin
            cnt_d      = ld_cnt;
            pre_d      = '0;
            rst_pend_d = 1'b0;
        end else if (en) begin
            if (pre_q == PTOP) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (rst_pend_q) begin
                    cnt_d      = '0;
                    rst_pend_d = 1'b0;
                end else begin
                    cnt_d  = inc_cnt;
                    wrap_d = inc_wrap;
                    if (carry) begin
                        ovf_d = 1'b1;
                    end
                end
                if (armed_q && (cnt_d == tgt_q)) begin
                    hit_d = 1'b1;
                    if (per_q) begin
                        rst_pend_d = 1'b1;
                    end else begin
                        armed_d = 1'b0;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        if (alarm_arm) begin
            tgt_d      = alarm_val;
            per_d      = alarm_periodic;
            armed_d    = 1'b1;
            rst_pend_d = 1'b0;
        end else if (alarm_cancel) begin
            armed_d    = 1'b0;
            rst_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q      <= '0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
            hit_q      <= 1'b0;
            tgt_q      <= '0;
            per_q      <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            armed_q    <= armed_d;
            hit_q      <= hit_d;
            tgt_q      <= tgt_d;
            per_q      <= per_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    assign count       = cnt_q;
    assign tick        = tick_q;
    assign stage_wrap  = wrap_q;
    assign overflow    = ovf_q;
    assign alarm_armed = armed_q;
    assign alarm_hit   = hit_q;

endmodule
